// File: rtl/seq_multiplier_carry_pkg.sv
// Shared types and constants for the shift-add multiplier (seq_multiplier_carry).
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN.
package seq_mult_pkg;

  localparam int SEQ_MULT_DEF_WIDTH = 8;
  localparam int SEQ_MULT_CNT_W     = $clog2(SEQ_MULT_DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_carry_if.sv
// Start/busy/done bus of the multiplier; signed_op exists only with SEQ_MULT_SIGNED_EN.
// Handshake: start is sampled on a rising edge only while busy=0; done pulses for
// one cycle when product/carry_out update, and start in that cycle is accepted.
interface seq_multiplier_carry_if #(
  parameter int WIDTH = seq_mult_pkg::SEQ_MULT_DEF_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 carry_in;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 signed_op;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 carry_out;

  modport master (
    output start, a, b, carry_in,
`ifdef SEQ_MULT_SIGNED_EN
    output signed_op,
`endif
    input  busy, done, product, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
`ifdef SEQ_MULT_SIGNED_EN
    input  signed_op,
`endif
    output busy, done, product, carry_out
  );

endinterface

// File: rtl/seq_multiplier_carry_dp.sv
// Shift-add datapath: accumulator high half, multiplier shift register and W+1-bit adder.
// o_acc_next is the full 2W-bit accumulator as it will be after the current step.
module mult_shift_add_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  input  logic [WIDTH-1:0]   i_acc_init,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_sum = {1'b0, r_acc_hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  end

  // The consumed multiplier bits vacate the low half as product bits shift in.
  assign o_acc_next = {w_sum, r_mplier[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_acc_hi <= i_acc_init;
      r_mplier <= i_mplier;
    end else if (i_step) begin
      r_acc_hi <= w_sum[WIDTH:1];
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_multiplier_carry.sv
// Multi-cycle multiply-with-carry: product = a*b + carry_in in WIDTH+1 cycles.
// Defining SEQ_MULT_SIGNED_EN adds the signed_op two's-complement mode.
module seq_multiplier_carry
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_multiplier_carry_if.slave  io_bus,
  output state_t                 o_state
);

  localparam int CNT_W = count_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [PW-1:0]      r_product;
  logic               r_carry_out;

  logic               w_load;
  logic               w_step;
  logic [WIDTH-1:0]   w_mcand;
  logic [WIDTH-1:0]   w_mplier;
  logic [WIDTH-1:0]   w_acc_init;
  logic [PW-1:0]      w_acc_next;
  logic [PW-1:0]      w_res;
  logic               w_co;

  assign w_load = (r_state != RUN) && io_bus.start;
  assign w_step = (r_state == RUN);

`ifdef SEQ_MULT_SIGNED_EN
  logic r_signed;
  logic r_neg;
  logic r_cin;
  logic [PW-1:0] w_fix;

  // Magnitudes are multiplied; sign and carry_in are applied on the last step.
  always_comb begin
    w_mcand    = (io_bus.signed_op && io_bus.a[WIDTH-1]) ? (~io_bus.a + WIDTH'(1)) : io_bus.a;
    w_mplier   = (io_bus.signed_op && io_bus.b[WIDTH-1]) ? (~io_bus.b + WIDTH'(1)) : io_bus.b;
    w_acc_init = '0;
    w_fix      = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;
    w_res      = w_fix + PW'(r_cin);
    w_co       = r_signed ? ~((&w_res[PW-1:WIDTH-1]) | ~(|w_res[PW-1:WIDTH-1]))
                          : (|w_res[PW-1:WIDTH]);
  end
`else
  // carry_in seeds the high half; after WIDTH right shifts it lands at weight 1.
  always_comb begin
    w_mcand    = io_bus.a;
    w_mplier   = io_bus.b;
    w_acc_init = {{(WIDTH-1){1'b0}}, io_bus.carry_in};
    w_res      = w_acc_next;
    w_co       = |w_res[PW-1:WIDTH];
  end
`endif

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (w_mcand),
    .i_mplier   (w_mplier),
    .i_acc_init (w_acc_init),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_product   <= '0;
      r_carry_out <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_signed    <= 1'b0;
      r_neg       <= 1'b0;
      r_cin       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          if (io_bus.start) begin
            r_state <= RUN;
            r_count <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
            r_signed <= io_bus.signed_op;
            r_neg    <= io_bus.signed_op & (io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1]);
            r_cin    <= io_bus.carry_in;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_count <= r_count - CNT_W'(1);
          // The final step's result is registered straight into the outputs.
          if (r_count == CNT_W'(1)) begin
            r_state     <= FIN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_product   <= w_res;
            r_carry_out <= w_co;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.product   = r_product;
  assign io_bus.carry_out = r_carry_out;
  assign o_state          = r_state;

endmodule

// File: tb/tb_seq_multiplier_carry.sv
// Directed bench for seq_multiplier_carry (WIDTH=8); signed vectors run when
// SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier_carry;
  import seq_mult_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_carry_if #(.WIDTH(W)) bus ();
  state_t dbg_state;

  seq_multiplier_carry #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_bus  (bus),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*W:0]   exp_q[$];        // {carry_out, product}
  logic [2*W:0]   mon_e;
  logic [2*W-1:0] last_prod;
  logic           last_co;
`ifdef SEQ_MULT_SIGNED_EN
  logic           sg_drive = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check("done_has_exp", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("result", {47'd0, bus.carry_out, bus.product}, {47'd0, mon_e});
        last_prod = mon_e[2*W-1:0];
        last_co   = mon_e[2*W];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic [2*W:0] e, input bit push);
    bus.start    = 1'b1;
    bus.a        = ia;
    bus.b        = ib;
    bus.carry_in = icin;
`ifdef SEQ_MULT_SIGNED_EN
    bus.signed_op = sg_drive;
`endif
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Busy cycles from_k..W with outputs held, then the done cycle.
  task automatic wait_run(input int from_k, input string tag);
    for (int k = from_k; k <= W; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, {62'd0, bus.busy, bus.done}, 64'd2);
      check({tag, "_hold"}, {47'd0, bus.carry_out, bus.product}, {47'd0, last_co, last_prod});
    end
    @(negedge clk);
    check({tag, "_done"}, {62'd0, bus.busy, bus.done}, 64'd1);
    check({tag, "_fin"}, 64'(dbg_state), 64'(FIN));
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                        input logic [2*W:0] e, input string tag);
    issue(ia, ib, icin, e, 1'b1);
    wait_run(1, tag);
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    last_prod = '0;
    last_co   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_done",  {63'd0, bus.done}, 64'd0);
    check("rst_prod",  {48'd0, bus.product}, 64'd0);
    check("rst_co",    {63'd0, bus.carry_out}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd15,  8'd13,  1'b0, {1'b0, 16'h00C3}, "m15x13");
    run_op(8'd255, 8'd255, 1'b1, {1'b1, 16'hFE02}, "max");
    run_op(8'd0,   8'd200, 1'b1, {1'b0, 16'h0001}, "zero");
    run_op(8'd1,   8'd255, 1'b1, {1'b1, 16'h0100}, "cross");

    // Second start while busy must be ignored.
    issue(8'd7, 8'd9, 1'b0, {1'b0, 16'h003F}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_run(3, "repulse");
    @(negedge clk);
    check("repulse_pulse", {63'd0, bus.done}, 64'd0);
    check("repulse_idle", 64'(dbg_state), 64'(IDLE));

    // Back-to-back: next start issued in the done cycle.
    issue(8'd3, 8'd4, 1'b0, {1'b0, 16'h000C}, 1'b1);
    wait_run(1, "b2b1");
    issue(8'd5, 8'd6, 1'b0, {1'b0, 16'h001E}, 1'b1);
    wait_run(1, "b2b2");
    @(negedge clk);
    check("b2b_pulse", {63'd0, bus.done}, 64'd0);

    // Asynchronous reset in the middle of an operation.
    issue(8'd7, 8'd9, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  {63'd0, bus.busy}, 64'd0);
    check("arst_done",  {63'd0, bus.done}, 64'd0);
    check("arst_prod",  {48'd0, bus.product}, 64'd0);
    check("arst_co",    {63'd0, bus.carry_out}, 64'd0);
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    last_prod = '0;
    last_co   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("arst_nodone", {63'd0, bus.done}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("arst_quiet", {62'd0, bus.busy, bus.done}, 64'd0);
    end
    run_op(8'd200, 8'd2, 1'b0, {1'b1, 16'h0190}, "post_rst");

`ifdef SEQ_MULT_SIGNED_EN
    sg_drive = 1'b1;
    run_op(8'hFD, 8'd5,  1'b0, {1'b0, 16'hFFF1}, "s_m3x5");
    run_op(8'h80, 8'h80, 1'b0, {1'b1, 16'h4000}, "s_min");
    run_op(8'hFF, 8'hFF, 1'b1, {1'b0, 16'h0002}, "s_m1m1c");
    sg_drive = 1'b0;
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
